imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, registered immediate extender for the decode-to-execute boundary of the multi-stage processor. It accepts an IN_W-bit immediate plus an extension mode and produces an OUT_W-bit operand. Supported modes are zero-extend, sign-extend, upper-load and branch offset. Results are delivered through a valid/ready pipeline register backed by a one-entry skid buffer, so decode sees a registered ready and no immediate is lost under execute-stage stalls.

## Interface
- IN_W, default 16, immediate input width; must be at least 2.
- OUT_W, default 32, output operand width; must satisfy OUT_W >= IN_W + 2.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  an immediate is offered this cycle.
- in_ready  output  1  block can accept; registered, equals !skid_valid.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- out_valid  output  1  out_imm holds a valid operand.
- out_ready  input  1  consumer accepts out_imm this cycle.
- out_imm  output  OUT_W  extended operand, registered.
- occupancy  output  2  entries held (0, 1 or 2).

## Operation
- Extension function, computed combinationally on the input side and then registered:
  - 00: upper OUT_W-IN_W bits are 0.
  - 01: upper bits are replicated from in_imm[IN_W-1].
  - 10: in_imm is placed at bits [OUT_W-1:OUT_W-IN_W]; low bits are 0.
  - 11: sign-extend, then shift left by 2; bits [1:0] are 0 and bits shifted out at the top are discarded.
- Storage:
  - main entry: out_imm with out_valid.
  - skid entry: skid_imm with skid_valid. The skid always holds extended data.
- Input is accepted when in_valid && in_ready.
- Output is consumed when out_valid && out_ready.
- Per-edge update, when flush is 0:
  - Main empty, or main consumed: main loads the skid if skid_valid, otherwise the accepted input, otherwise goes empty.
  - When main loads from the skid and an input is also accepted in the same cycle, that input goes to the skid.
  - Main full, not consumed, input accepted: input goes to the skid.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- flush = 1: at the next edge out_valid and skid_valid are cleared. in_valid in the flush cycle is ignored. Flush has priority over accept and consume.
- occupancy = out_valid + skid_valid.
- Reset, asynchronous:
  - out_valid = 0, skid_valid = 0, in_ready = 1, occupancy = 0.
  - out_imm = 0 and skid_imm = 0.
  - Any held entries are discarded immediately when reset asserts.

## Timing
- Latency: an input accepted at edge N appears on out_imm and out_valid after edge N.
- Throughput: one operand per cycle while out_ready stays high.
- in_ready is driven only from a flop. It never depends combinationally on out_ready or in_valid.
- in_ready falls the cycle after the skid fills. It rises the cycle after the skid drains.
- Simultaneous accept and consume with occupancy 1: occupancy stays 1 and main takes the new input.
- Occupancy 2 with out_ready = 1 and in_valid = 1: main takes the skid. in_ready is 0 that cycle, so the input is not accepted; occupancy becomes 1.
- out_imm is held stable while out_valid && !out_ready.
- Deasserting reset takes effect at the next clk edge; the first accept is possible on that edge.

## Configuration
- IMMEXT_BRANCH_EN defined: mode 11 performs sign-extend then shift-left-2, as described under Operation.
- IMMEXT_BRANCH_EN undefined: mode 11 is identical to mode 01 (plain sign-extend). The shifter logic is not synthesised. All other behaviour is unchanged.

## Test plan
All scenarios use IN_W=16 and OUT_W=32.
- Sign-extend: imm 0x8001, mode 01, out_ready=1 -> out_imm=0xFFFF8001 with out_valid one cycle later. Imm 0x7FFF, mode 01 -> 0x00007FFF.
- Zero and upper: 0x8001 mode 00 -> 0x00008001. 0x1234 mode 10 -> 0x12340000. Issued back to back, outputs appear on consecutive cycles.
- Branch: 0xFFFF mode 11 -> 0xFFFFFFFC and 0x0004 mode 11 -> 0x00000010 with IMMEXT_BRANCH_EN. Without the macro: 0xFFFF mode 11 -> 0xFFFFFFFF.
- Backpressure: out_ready=0, send A=0x0001 then B=0x0002 (mode 00).
  - Occupancy goes 1 then 2; in_ready=0 the cycle after B; a third input C is held off.
  - Raise out_ready: A, then B, then C are delivered in order with no loss.
- Flush: with occupancy 2, pulse flush while in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, and the flush-cycle input is absent.
- Reset mid-operation: assert reset asynchronously between edges with occupancy 2 -> immediately out_valid=0, in_ready=1, occupancy=0, out_imm=0. After release the next accepted input emerges normally.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (zero/sign/upper/branch) with a one-entry skid buffer.
// Define IMMEXT_BRANCH_EN to make mode 11 shift the sign-extended immediate left by 2.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [1:0]       occupancy
);

  logic [OUT_W-1:0] ext_zero, ext_sign, ext_upper, ext_val;
  logic [OUT_W-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic             accept, consume;

  assign ext_zero  = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign ext_sign  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign ext_upper = {in_imm, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    ext_val = ext_zero;
    unique case (in_mode)
      2'b00: ext_val = ext_zero;
      2'b01: ext_val = ext_sign;
      2'b10: ext_val = ext_upper;
`ifdef IMMEXT_BRANCH_EN
      2'b11: ext_val = {ext_sign[OUT_W-3:0], 2'b00};
`else
      2'b11: ext_val = ext_sign;
`endif
      default: ext_val = ext_zero;
    endcase
  end

  // in_ready comes straight from the skid flop, so it never sees out_ready combinationally.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || consume) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        skid_valid_d = accept;
        if (accept) skid_imm_d = ext_val;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = ext_val;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = ext_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed-vector bench for imm_extend_pipe (IN_W=16, OUT_W=32).
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 2'b00);
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_occ", {30'b0, occupancy}, 32'd0);
    check("rst_out_imm", out_imm, 32'h0);
    step();
    reset = 1'b0;

    // Extension modes, back to back with out_ready high
    out_ready = 1'b1;
    drive(1'b1, 16'h8001, 2'b01); step();
    check("sext_valid", {31'b0, out_valid}, 32'd1);
    check("sext_neg", out_imm, 32'hFFFF8001);
    drive(1'b1, 16'h7FFF, 2'b01); step();
    check("sext_pos", out_imm, 32'h00007FFF);
    drive(1'b1, 16'h8001, 2'b00); step();
    check("zext", out_imm, 32'h00008001);
    drive(1'b1, 16'h1234, 2'b10); step();
    check("upper", out_imm, 32'h12340000);
    check("upper_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b1, 16'hFFFF, 2'b11); step();
`ifdef IMMEXT_BRANCH_EN
    check("branch_neg", out_imm, 32'hFFFFFFFC);
`else
    check("branch_neg", out_imm, 32'hFFFFFFFF);
`endif
    drive(1'b1, 16'h0004, 2'b11); step();
`ifdef IMMEXT_BRANCH_EN
    check("branch_pos", out_imm, 32'h00000010);
`else
    check("branch_pos", out_imm, 32'h00000004);
`endif
    drive(1'b0, 16'h0, 2'b00); step();
    check("drain_valid", {31'b0, out_valid}, 32'd0);
    check("drain_occ", {30'b0, occupancy}, 32'd0);

    // Backpressure: A, B fill main and skid, C is held off
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'b00); step();
    check("bp_occ1", {30'b0, occupancy}, 32'd1);
    check("bp_ready1", {31'b0, in_ready}, 32'd1);
    drive(1'b1, 16'h0002, 2'b00); step();
    check("bp_occ2", {30'b0, occupancy}, 32'd2);
    check("bp_ready0", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 16'h0003, 2'b00); step();
    check("bp_hold_occ", {30'b0, occupancy}, 32'd2);
    check("bp_hold_imm", out_imm, 32'h00000001);
    out_ready = 1'b1; step();
    check("bp_b_imm", out_imm, 32'h00000002);
    check("bp_b_occ", {30'b0, occupancy}, 32'd1);
    check("bp_b_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp_c_imm", out_imm, 32'h00000003);
    check("bp_c_occ", {30'b0, occupancy}, 32'd1);
    drive(1'b0, 16'h0, 2'b00); step();
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush at occupancy 2 with in_valid high
    out_ready = 1'b0;
    drive(1'b1, 16'h000A, 2'b00); step();
    drive(1'b1, 16'h000B, 2'b00); step();
    check("fl_occ2", {30'b0, occupancy}, 32'd2);
    flush = 1'b1; drive(1'b1, 16'h000C, 2'b00); step();
    flush = 1'b0; drive(1'b0, 16'h0, 2'b00);
    check("fl_valid", {31'b0, out_valid}, 32'd0);
    check("fl_occ", {30'b0, occupancy}, 32'd0);
    check("fl_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("fl_absent", {31'b0, out_valid}, 32'd0);

    // Flush at occupancy 1 while an input would otherwise be accepted
    drive(1'b1, 16'h000D, 2'b00); step();
    flush = 1'b1; drive(1'b1, 16'h000E, 2'b00); step();
    flush = 1'b0; drive(1'b0, 16'h0, 2'b00);
    check("fl1_occ", {30'b0, occupancy}, 32'd0);

    // Asynchronous reset mid-operation
    drive(1'b1, 16'h0011, 2'b00); step();
    drive(1'b1, 16'h0022, 2'b00); step();
    check("ar_occ2", {30'b0, occupancy}, 32'd2);
    drive(1'b0, 16'h0, 2'b00);
    #2 reset = 1'b1;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_ready", {31'b0, in_ready}, 32'd1);
    check("ar_occ", {30'b0, occupancy}, 32'd0);
    check("ar_imm", out_imm, 32'h0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'h0033, 2'b01); step();
    check("ar_post_valid", {31'b0, out_valid}, 32'd1);
    check("ar_post_imm", out_imm, 32'h00000033);
    drive(1'b0, 16'h0, 2'b00); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
